// File: rtl/divclk_monitor.sv
// divclk_monitor: brings a slow divided clock into the clk domain as edge strobes, measures its
// period, tracks lock and flags loss of clock. Define DIVCLK_DUTY_EN to also measure the high time.
module divclk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             div_clk_in,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             lost,
  output logic [CNT_W-1:0] high_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    LOCKING,
    LOCKED,
    LOST
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_V    = 4'(LOCK_COUNT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_out;
  logic                   p;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt;
  logic                   timeout;
  logic [3:0]             match_cnt;
  logic [3:0]             match_next;
  state_t                 state;
  state_t                 state_next;
  logic                   capture;

  assign s_out   = sync[SYNC_STAGES-1];
  assign rise    = s_out & ~p;
  assign fall    = ~s_out & p;
  assign timeout = (cnt >= TIMEOUT_V);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      p        <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], div_clk_in};
      p        <= s_out;
      rise_stb <= rise;
      fall_stb <= fall;
    end
  end

  // Cycles since the last rise; saturates so a very slow clock never aliases to a short period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    match_next = match_cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_next = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          capture    = 1'b1;
          match_next = 4'd1;
          state_next = (LOCK_V <= 4'd1) ? LOCKED : LOCKING;
        end else if (timeout) begin
          state_next = LOST;
        end
      end
      LOCKING: begin
        if (rise) begin
          capture    = 1'b1;
          match_next = (cnt == period) ? match_cnt + 4'd1 : 4'd1;
          if (match_next >= LOCK_V) state_next = LOCKED;
        end else if (timeout) begin
          state_next = LOST;
        end
      end
      LOCKED: begin
        if (rise) begin
          capture = 1'b1;
          if (cnt != period) begin
            match_next = 4'd1;
            state_next = LOCKING;
          end
        end else if (timeout) begin
          state_next = LOST;
        end
      end
      LOST: begin
        if (rise) state_next = MEASURE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      match_cnt  <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      state      <= state_next;
      match_cnt  <= match_next;
      period_vld <= capture;
      if (capture) period <= cnt;
    end
  end

  assign locked = (state == LOCKED);
  assign lost   = (state == LOST);

`ifdef DIVCLK_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic             seen_rise;

  // A fall only describes a real high phase once a rise has been seen since reset or loss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt      <= '0;
      seen_rise <= 1'b0;
      high_cnt  <= '0;
    end else begin
      if (rise) begin
        hcnt <= CNT_W'(1);
      end else if (s_out && hcnt != CNT_MAX) begin
        hcnt <= hcnt + 1'b1;
      end
      if (rise) begin
        seen_rise <= 1'b1;
      end else if (state_next == LOST && state != LOST) begin
        seen_rise <= 1'b0;
      end
      if (fall && seen_rise) high_cnt <= hcnt;
    end
  end
`else
  assign high_cnt = '0;
`endif

endmodule

// File: tb/tb_divclk_monitor.sv
// tb_divclk_monitor: drives two monitors (CNT_W 8/TIMEOUT 255 and CNT_W 9/TIMEOUT 400) from one
// divided clock and compares every cycle against an event-level model of rises, gaps and timeouts.
module tb_divclk_monitor;

  localparam int SYNC  = 2;
  localparam int LOCKN = 4;
`ifdef DIVCLK_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       div_clk_in = 1'b0;
  logic       rise_a, fall_a, vld_a, locked_a, lost_a;
  logic [7:0] period_a, high_a;
  logic       rise_b, fall_b, vld_b, locked_b, lost_b;
  logic [8:0] period_b, high_b;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_seen = 0;

  divclk_monitor #(.SYNC_STAGES(SYNC), .CNT_W(8), .LOCK_COUNT(LOCKN), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset_n(reset_n), .div_clk_in(div_clk_in),
    .rise_stb(rise_a), .fall_stb(fall_a), .period(period_a), .period_vld(vld_a),
    .locked(locked_a), .lost(lost_a), .high_cnt(high_a)
  );

  divclk_monitor #(.SYNC_STAGES(SYNC), .CNT_W(9), .LOCK_COUNT(LOCKN), .TIMEOUT(400)) dut_b (
    .clk(clk), .reset_n(reset_n), .div_clk_in(div_clk_in),
    .rise_stb(rise_b), .fall_stb(fall_b), .period(period_b), .period_vld(vld_b),
    .locked(locked_b), .lost(lost_b), .high_cnt(high_b)
  );

  always #5 clk = ~clk;

  // Model state: edge index since reset, recent input samples, and per-instance event history.
  int sat_v [2] = '{255, 511};
  int to_v  [2] = '{255, 400};
  int edge_n = 0;
  bit hist[$];
  bit e_rise = 1'b0;
  bit e_fall = 1'b0;
  int last_rise [2] = '{0, 0};
  int rc        [2] = '{0, 0};
  int streak    [2] = '{0, 0};
  int e_period  [2] = '{0, 0};
  int e_high    [2] = '{0, 0};
  bit e_vld     [2] = '{1'b0, 1'b0};
  bit e_lost    [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge reset_n) begin : model
    bit cur, prv;
    int gap;
    if (!reset_n) begin
      edge_n = 0;
      hist.delete();
      e_rise = 1'b0;
      e_fall = 1'b0;
      for (int i = 0; i < 2; i++) begin
        last_rise[i] = 0; rc[i] = 0; streak[i] = 0; e_period[i] = 0;
        e_high[i] = 0; e_vld[i] = 1'b0; e_lost[i] = 1'b0;
      end
    end else begin
      edge_n++;
      hist.push_back(div_clk_in);
      cur = (hist.size() > SYNC) ? hist[hist.size()-1-SYNC] : 1'b0;
      prv = (hist.size() > SYNC+1) ? hist[hist.size()-2-SYNC] : 1'b0;
      while (hist.size() > SYNC + 2) void'(hist.pop_front());
      e_rise = cur & ~prv;
      e_fall = ~cur & prv;
      for (int i = 0; i < 2; i++) begin
        gap = edge_n - last_rise[i];
        if (gap > sat_v[i]) gap = sat_v[i];
        e_vld[i] = 1'b0;
        if (e_fall && rc[i] >= 1) e_high[i] = gap;
        if (e_rise) begin
          if (e_lost[i]) begin
            e_lost[i] = 1'b0;
            rc[i] = 0;
          end
          rc[i]++;
          if (rc[i] >= 2) begin
            e_vld[i] = 1'b1;
            streak[i] = (rc[i] > 2 && gap == e_period[i]) ? streak[i] + 1 : 1;
            e_period[i] = gap;
          end
          last_rise[i] = edge_n;
        end else if (rc[i] >= 1 && edge_n - last_rise[i] >= to_v[i]) begin
          e_lost[i] = 1'b1;
          streak[i] = 0;
          rc[i] = 0;
        end
      end
    end
  end

  task automatic check_output(input string name, input int inst,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s inst%0d t=%0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (vld_a) vld_seen++;
      check_output("rise_stb",   0, 32'(rise_a),   32'(e_rise));
      check_output("fall_stb",   0, 32'(fall_a),   32'(e_fall));
      check_output("period",     0, 32'(period_a), 32'(e_period[0]));
      check_output("period_vld", 0, 32'(vld_a),    32'(e_vld[0]));
      check_output("locked",     0, 32'(locked_a), 32'(streak[0] >= LOCKN));
      check_output("lost",       0, 32'(lost_a),   32'(e_lost[0]));
      check_output("high_cnt",   0, 32'(high_a),   DUTY_EN ? 32'(e_high[0]) : 32'd0);
      check_output("rise_stb",   1, 32'(rise_b),   32'(e_rise));
      check_output("fall_stb",   1, 32'(fall_b),   32'(e_fall));
      check_output("period",     1, 32'(period_b), 32'(e_period[1]));
      check_output("period_vld", 1, 32'(vld_b),    32'(e_vld[1]));
      check_output("locked",     1, 32'(locked_b), 32'(streak[1] >= LOCKN));
      check_output("lost",       1, 32'(lost_b),   32'(e_lost[1]));
      check_output("high_cnt",   1, 32'(high_b),   DUTY_EN ? 32'(e_high[1]) : 32'd0);
    end
  end

  task automatic check_zero();
    check_output("rst_rise",   0, 32'(rise_a),   0);
    check_output("rst_fall",   0, 32'(fall_a),   0);
    check_output("rst_period", 0, 32'(period_a), 0);
    check_output("rst_vld",    0, 32'(vld_a),    0);
    check_output("rst_locked", 0, 32'(locked_a), 0);
    check_output("rst_lost",   0, 32'(lost_a),   0);
    check_output("rst_high",   0, 32'(high_a),   0);
    check_output("rst_period", 1, 32'(period_b), 0);
    check_output("rst_locked", 1, 32'(locked_b), 0);
    check_output("rst_vld",    1, 32'(vld_b),    0);
  endtask

  task automatic apply_stimulus(input int div, input int high, input int periods);
    for (int k = 0; k < periods; k++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        div_clk_in = (c < high);
      end
    end
  endtask

  task automatic hold_level(input bit lvl, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      div_clk_in = lvl;
    end
  endtask

  // Reset lands mid-cycle so the outputs must clear without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_zero();
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    int r, dv, hi;
    reset_n = 1'b0;
    div_clk_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero();
    #2 reset_n = 1'b1;

    vld_seen = 0;
    apply_stimulus(4, 2, 20);
    hold_level(1'b0, 4);
    check_output("t1_period", 0, 32'(period_a), 4);
    check_output("t1_locked", 0, 32'(locked_a), 1);
    check_output("t1_vld_count", 0, 32'(vld_seen), 19);

    apply_stimulus(8, 4, 5);
    check_output("t2_period", 0, 32'(period_a), 8);
    check_output("t2_locked", 0, 32'(locked_a), 1);

    hold_level(1'b0, 260);
    check_output("t3_lost", 0, 32'(lost_a), 1);
    check_output("t3_locked", 0, 32'(locked_a), 0);
    check_output("t3_lost", 1, 32'(lost_b), 0);
    hold_level(1'b0, 150);
    check_output("t3_lost_late", 1, 32'(lost_b), 1);
    apply_stimulus(8, 4, 3);

    apply_stimulus(16, 8, 3);
    do_reset();
    apply_stimulus(16, 8, 3);
    check_output("t4_period", 0, 32'(period_a), 16);

    apply_stimulus(300, 150, 3);
    check_output("t5_period_held", 0, 32'(period_a), 16);
    check_output("t5_lost", 0, 32'(lost_a), 1);
    check_output("t5_period", 1, 32'(period_b), 300);

    apply_stimulus(8, 3, 6);
    check_output("t6_period", 0, 32'(period_a), 8);
    check_output("t6_high", 0, 32'(high_a), DUTY_EN ? 32'd3 : 32'd0);

    hold_level(1'b1, 300);
    check_output("stuck_high_lost", 0, 32'(lost_a), 1);
    hold_level(1'b0, 10);

    for (int seg = 0; seg < 40; seg++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_reset();
      end else if (r == 1) begin
        hold_level(1'($urandom_range(0, 1)), $urandom_range(200, 450));
      end else begin
        dv = $urandom_range(2, 24);
        hi = $urandom_range(1, dv - 1);
        apply_stimulus(dv, hi, $urandom_range(1, 10));
      end
    end
    hold_level(1'b0, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
